// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared widths and queue-select encodings for the parking record queue
package parking_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic SEL_P = 1'b0;
  localparam logic SEL_Q = 1'b1;
endpackage

// File: rtl/record_fifo.sv
// rtl/record_fifo.sv - circular-buffer record queue; head is presented on dout, popped on the clock edge
module record_fifo
  import parking_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Callers only push when a slot is free or a pop frees one in the same cycle
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/parking_record_queue.sv
// rtl/parking_record_queue.sv - edge-detected capture of controller records into queues P and Q with a read port
module parking_record_queue
  import parking_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enable_p,
  input  logic              enable_q,
  input  logic              rd_req,
  input  logic              rd_sel,
  input  logic              clear_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  count_p,
  output logic [CNT_W-1:0]  count_q,
  output logic              full_p,
  output logic              full_q,
  output logic              empty_p,
  output logic              empty_q,
  output logic              overflow,
  output logic              underflow,
  output logic              collision
);

  logic              enable_p_d;
  logic              enable_q_d;
  logic              rise_p;
  logic              rise_q;
  logic              wr_p;
  logic              wr_q;
  logic              rd_p;
  logic              rd_q;
  logic              push_p;
  logic              push_q;
  logic              overflow_evt;
  logic              underflow_evt;
  logic              collision_evt;
  logic [DATA_W-1:0] dout_p;
  logic [DATA_W-1:0] dout_q;

  assign rise_p = enable_p & ~enable_p_d;
  assign rise_q = enable_q & ~enable_q_d;

  // P wins a simultaneous rise; the Q record is dropped and flagged
  assign wr_p          = rise_p;
  assign wr_q          = rise_q & ~rise_p;
  assign collision_evt = rise_p & rise_q;

  assign rd_p = rd_req & (rd_sel == SEL_P) & ~empty_p;
  assign rd_q = rd_req & (rd_sel == SEL_Q) & ~empty_q;

  // A same-cycle pop of a full queue frees the slot the write lands in
  assign push_p = wr_p & (~full_p | rd_p);
  assign push_q = wr_q & (~full_q | rd_q);

  assign overflow_evt  = (wr_p & full_p & ~rd_p) | (wr_q & full_q & ~rd_q);
  assign underflow_evt = rd_req & ((rd_sel == SEL_P) ? empty_p : empty_q);

  record_fifo u_fifo_p (
    .clock (clock),
    .reset (reset),
    .push  (push_p),
    .pop   (rd_p),
    .din   (data_in),
    .dout  (dout_p),
    .count (count_p),
    .full  (full_p),
    .empty (empty_p)
  );

  record_fifo u_fifo_q (
    .clock (clock),
    .reset (reset),
    .push  (push_q),
    .pop   (rd_q),
    .din   (data_in),
    .dout  (dout_q),
    .count (count_q),
    .full  (full_q),
    .empty (empty_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable_p_d <= 1'b0;
      enable_q_d <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      enable_p_d <= enable_p;
      enable_q_d <= enable_q;
      rd_valid   <= rd_p | rd_q;
      if (rd_p) begin
        rd_data <= dout_p;
      end else if (rd_q) begin
        rd_data <= dout_q;
      end
    end
  end

  // New errors take priority over a same-cycle clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      collision <= 1'b0;
    end else begin
      if (overflow_evt) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
      if (underflow_evt) begin
        underflow <= 1'b1;
      end else if (clear_err) begin
        underflow <= 1'b0;
      end
      if (collision_evt) begin
        collision <= 1'b1;
      end else if (clear_err) begin
        collision <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parking_record_queue.sv
// tb/tb_parking_record_queue.sv - directed vector bench for parking_record_queue
module tb_parking_record_queue;

  typedef struct {
    logic       rst;
    logic       ep;
    logic       eq;
    logic [7:0] din;
    logic       rr;
    logic       rs;
    logic       ce;
    logic       ev;
    logic [7:0] ed;
    int         cp;
    int         cq;
    logic       ov;
    logic       un;
    logic       col;
  } vec_t;

  logic       clock;
  logic       reset;
  logic [7:0] data_in;
  logic       enable_p;
  logic       enable_q;
  logic       rd_req;
  logic       rd_sel;
  logic       clear_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] count_p;
  logic [2:0] count_q;
  logic       full_p;
  logic       full_q;
  logic       empty_p;
  logic       empty_q;
  logic       overflow;
  logic       underflow;
  logic       collision;

  int n_vec;
  int n_bad;
  vec_t vecs[$];

  parking_record_queue dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .enable_p  (enable_p),
    .enable_q  (enable_q),
    .rd_req    (rd_req),
    .rd_sel    (rd_sel),
    .clear_err (clear_err),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count_p   (count_p),
    .count_q   (count_q),
    .full_p    (full_p),
    .full_q    (full_q),
    .empty_p   (empty_p),
    .empty_q   (empty_q),
    .overflow  (overflow),
    .underflow (underflow),
    .collision (collision)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic rst, input logic ep, input logic eq, input logic [7:0] din,
                              input logic rr, input logic rs, input logic ce,
                              input logic ev, input logic [7:0] ed, input int cp, input int cq,
                              input logic ov, input logic un, input logic col);
    vec_t v;
    v.rst = rst; v.ep = ep; v.eq = eq; v.din = din; v.rr = rr; v.rs = rs; v.ce = ce;
    v.ev = ev; v.ed = ed; v.cp = cp; v.cq = cq; v.ov = ov; v.un = un; v.col = col;
    return v;
  endfunction

  task automatic cmp(input string name, input string field, input int act, input int exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %0h, expected %0h", name, field, act, exp);
    end
  endtask

  task automatic check(input string name, input logic ev, input logic [7:0] ed, input int cp, input int cq,
                       input logic ov, input logic un, input logic col);
    n_vec++;
    cmp(name, "rd_valid", int'(rd_valid), int'(ev));
    cmp(name, "rd_data", int'(rd_data), int'(ed));
    cmp(name, "count_p", int'(count_p), cp);
    cmp(name, "count_q", int'(count_q), cq);
    cmp(name, "full_p", int'(full_p), int'(cp == 4));
    cmp(name, "full_q", int'(full_q), int'(cq == 4));
    cmp(name, "empty_p", int'(empty_p), int'(cp == 0));
    cmp(name, "empty_q", int'(empty_q), int'(cq == 0));
    cmp(name, "overflow", int'(overflow), int'(ov));
    cmp(name, "underflow", int'(underflow), int'(un));
    cmp(name, "collision", int'(collision), int'(col));
  endtask

  task automatic drive(input logic ep, input logic eq, input logic [7:0] din,
                       input logic rr, input logic rs, input logic ce);
    enable_p = ep; enable_q = eq; data_in = din; rd_req = rr; rd_sel = rs; clear_err = ce;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_state", 1'b0, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0);

    // Mid-stream asynchronous reset
    drive(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 8'hA2, 1'b0, 1'b0, 1'b0); step();
    check("pre_reset_two_in_p", 1'b0, 8'h00, 2, 0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_mid", 1'b0, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0); step();
    check("rd_after_reset", 1'b0, 8'h00, 0, 0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    //              rst  ep   eq   din    rr   rs   ce     ev   ed   cp cq  ov   un   col
    // Held enable gives one record
    vecs.push_back(mk(1, 1, 0, 8'hF3, 0, 0, 0,   0, 8'h00, 1, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 1, 0, 8'hF3, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'hF3, 1, 0, 0,   1, 8'hF3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0,   0, 8'hF3, 0, 0, 0, 0, 0));
    // Fill Q, overflow, drain, underflow, clear
    vecs.push_back(mk(1, 0, 1, 8'h01, 0, 0, 0,   0, 8'h00, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h01, 0, 0, 0,   0, 8'h00, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h02, 0, 0, 0,   0, 8'h00, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h02, 0, 0, 0,   0, 8'h00, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h03, 0, 0, 0,   0, 8'h00, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h03, 0, 0, 0,   0, 8'h00, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h04, 0, 0, 0,   0, 8'h00, 0, 4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h04, 0, 0, 0,   0, 8'h00, 0, 4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h05, 0, 0, 0,   0, 8'h00, 0, 4, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h05, 0, 0, 0,   0, 8'h00, 0, 4, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,   1, 8'h01, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,   1, 8'h02, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,   1, 8'h03, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,   1, 8'h04, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,   0, 8'h04, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1,   0, 8'h04, 0, 0, 0, 0, 0));
    // Full Q with simultaneous push and pop
    vecs.push_back(mk(1, 0, 1, 8'h01, 0, 0, 0,   0, 8'h00, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h01, 0, 0, 0,   0, 8'h00, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h02, 0, 0, 0,   0, 8'h00, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h02, 0, 0, 0,   0, 8'h00, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h03, 0, 0, 0,   0, 8'h00, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h03, 0, 0, 0,   0, 8'h00, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h04, 0, 0, 0,   0, 8'h00, 0, 4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h04, 0, 0, 0,   0, 8'h00, 0, 4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h09, 1, 1, 0,   1, 8'h01, 0, 4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,   1, 8'h02, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,   1, 8'h03, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,   1, 8'h04, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,   1, 8'h09, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0,   0, 8'h09, 0, 0, 0, 0, 0));
    // Collision, clear, and new error winning over clear
    vecs.push_back(mk(1, 1, 1, 8'hAA, 0, 0, 0,   0, 8'h00, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1,   0, 8'h00, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0,   1, 8'hAA, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'hBB, 0, 0, 1,   0, 8'hAA, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1,   0, 8'hAA, 1, 0, 0, 0, 0));
    // Wrap-around on P
    for (int k = 0; k < 10; k++) begin
      vecs.push_back(mk(k == 0, 1, 0, 8'(8'h10 + k), 0, 0, 0,
                        0, (k == 0) ? 8'h00 : 8'(8'h10 + k - 1), 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 8'(8'h10 + k), 0, 0, 0, 0, 0));
    end
    // Read of empty P with same-cycle write; then write Q while reading P
    vecs.push_back(mk(1, 1, 0, 8'h55, 1, 0, 0,   0, 8'h00, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h66, 1, 0, 0,   1, 8'h55, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,   1, 8'h66, 0, 0, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
      end
      drive(vecs[i].ep, vecs[i].eq, vecs[i].din, vecs[i].rr, vecs[i].rs, vecs[i].ce);
      step();
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].cp, vecs[i].cq,
            vecs[i].ov, vecs[i].un, vecs[i].col);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
